// File: rtl/encrypt_stream_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// encrypt_stream_ctrl_pkg
//   Shared constants and types for the byte-stream wrapper around the
//   128-bit block / 64-bit key, 32-round encryption core.
//   Contents:
//     BLK_BYTES, BLK_W, KEY_W, ROUNDS  block geometry of the core
//     TIMEOUT_DEF                      default RUN watchdog limit (cycles)
//     CNT_W, WD_W                      byte-counter and watchdog widths
//     state_e                          controller FSM encoding (2-bit)
//     wd_inc()                         saturating watchdog increment
// ----------------------------------------------------------------------------
package encrypt_stream_ctrl_pkg;

    localparam int BLK_BYTES   = 16;
    localparam int BLK_W       = 128;
    localparam int KEY_W       = 64;
    localparam int ROUNDS      = 32;
    localparam int TIMEOUT_DEF = 48;

    localparam int CNT_W = 4;
    localparam int WD_W  = 6;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Watchdog never wraps back to a small value, so a stuck core can
    // never look like a freshly started one.
    function automatic logic [WD_W-1:0] wd_inc(input logic [WD_W-1:0] v);
        return (v == '1) ? v : v + WD_W'(1);
    endfunction

endpackage

// File: rtl/encrypt_stream_ctrl_serializer.sv
// ----------------------------------------------------------------------------
// enc_byte_serializer
//   Holds one 128-bit cipher block and presents it as 16 bytes on a
//   valid/ready byte port, byte 0 = block_i[0:7] first.
//   Ports:
//     clk_i, rst_i     clock, synchronous active-high reset
//     load_i           capture block_i, start presenting byte 0
//     block_i[0:127]   block to serialise
//     m_data_o[7:0]    current byte (stable while m_valid_o & !m_ready_i)
//     m_valid_o        byte available
//     m_ready_i        sink takes the byte
//     done_o           high in the cycle the 16th byte is transferred
//
//   Handshake: a byte moves on every rising edge where valid and ready are
//   both high; valid never drops and data never changes until that happens.
// ----------------------------------------------------------------------------
module enc_byte_serializer
    import encrypt_stream_ctrl_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [0:BLK_W-1] block_i,
    output logic [7:0]       m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic             done_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLK_BYTES - 1);

    logic [0:BLK_W-1] buf_q, buf_d;
    logic [CNT_W-1:0] ocnt_q, ocnt_d;
    logic             valid_q, valid_d;
    logic             xfer;

    assign xfer = valid_q & m_ready_i;

    always_comb begin
        buf_d   = buf_q;
        ocnt_d  = ocnt_q;
        valid_d = valid_q;
        if (load_i) begin
            buf_d   = block_i;
            ocnt_d  = '0;
            valid_d = 1'b1;
        end else if (xfer) begin
            // Counter wraps 15 -> 0 on the last byte, ready for the next block.
            ocnt_d = ocnt_q + CNT_W'(1);
            if (ocnt_q == LAST) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_q   <= '0;
            ocnt_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            ocnt_q  <= ocnt_d;
            valid_q <= valid_d;
        end
    end

    assign m_data_o  = buf_q[{ocnt_q, 3'b000} +: 8];
    assign m_valid_o = valid_q;
    assign done_o    = xfer & (ocnt_q == LAST);

endmodule

// File: rtl/encrypt_stream_ctrl.sv
// ----------------------------------------------------------------------------
// encrypt_stream_ctrl
//   Byte-stream front/back end for the encryption core. Packs 16 input bytes
//   into Plain, raises encrypt_start, captures Cipher on the first
//   encrypt_end cycle and streams the 16 cipher bytes out.
//   Ports:
//     clock, reset           clock, synchronous active-high reset
//     s_data/s_valid/s_ready plaintext byte input (accepted in FILL only)
//     key_in[0:63],key_load  key register write (honoured in FILL only)
//     m_data/m_valid/m_ready cipher byte output
//     Plain[0:127], Key[0:63], encrypt_start   to the core
//     encrypt_end, Cipher[0:127]               from the core
//     timeout_err            one-cycle pulse when RUN is aborted
//     dbg_state              current FSM state (state_e encoding)
//
//   Handshake on both byte ports: a byte moves on every rising edge where
//   valid and ready are both high.
//   Flow: FILL (16 bytes) -> LOAD (1 cycle, start low) -> RUN (start high
//   until encrypt_end or watchdog) -> DRAIN (16 bytes out) -> FILL.
// ----------------------------------------------------------------------------
module encrypt_stream_ctrl
    import encrypt_stream_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
)(
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [0:KEY_W-1] key_in,
    input  logic             key_load,
    output logic [7:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [0:BLK_W-1] Plain,
    output logic [0:KEY_W-1] Key,
    output logic             encrypt_start,
    input  logic             encrypt_end,
    input  logic [0:BLK_W-1] Cipher,
    output logic             timeout_err,
    output logic [1:0]       dbg_state
);

    localparam logic [CNT_W-1:0] LAST   = CNT_W'(BLK_BYTES - 1);
    localparam logic [WD_W-1:0]  WD_END = WD_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [0:BLK_W-1] plain_q, plain_d;
    logic [0:KEY_W-1] key_q, key_d;
    logic             start_q, start_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             tmo_q, tmo_d;

    logic fill_xfer;
    logic cipher_take;
    logic wd_expired;
    logic ser_done;

    assign fill_xfer   = (state_q == ST_FILL) & s_valid;
    // Only the first encrypt_end cycle is used: the core keeps iterating
    // while start is high, but we leave RUN on that same edge.
    assign cipher_take = (state_q == ST_RUN) & encrypt_end;
    // wd_q counts RUN cycles from 0, so this is the last allowed RUN cycle.
    // A late encrypt_end in that cycle still wins over the abort.
    assign wd_expired  = (state_q == ST_RUN) & ~encrypt_end & (wd_q == WD_END);

    // ---------------- state register ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL:  if (fill_xfer && cnt_q == LAST) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_RUN;
            ST_RUN: begin
                if (cipher_take)     state_d = ST_DRAIN;
                else if (wd_expired) state_d = ST_FILL;
            end
            ST_DRAIN: if (ser_done) state_d = ST_FILL;
            default:  state_d = ST_FILL;
        endcase
    end

    // ---------------- output / datapath next values ----------------
    always_comb begin
        cnt_d   = cnt_q;
        plain_d = plain_q;
        key_d   = key_q;
        start_d = start_q;
        wd_d    = wd_q;
        tmo_d   = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (fill_xfer) begin
                    plain_d[{cnt_q, 3'b000} +: 8] = s_data;
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (key_load) begin
                    key_d = key_in;
                end
            end
            ST_LOAD: begin
                // Start stays low this cycle so the core reloads Plain/Key;
                // it goes high on the edge into RUN.
                start_d = 1'b1;
                wd_d    = '0;
            end
            ST_RUN: begin
                if (cipher_take) begin
                    start_d = 1'b0;
                end else if (wd_expired) begin
                    start_d = 1'b0;
                    tmo_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    wd_d = wd_inc(wd_q);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            plain_q <= '0;
            key_q   <= '0;
            start_q <= 1'b0;
            wd_q    <= '0;
            tmo_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            plain_q <= plain_d;
            key_q   <= key_d;
            start_q <= start_d;
            wd_q    <= wd_d;
            tmo_q   <= tmo_d;
        end
    end

    enc_byte_serializer u_ser (
        .clk_i     (clock),
        .rst_i     (reset),
        .load_i    (cipher_take),
        .block_i   (Cipher),
        .m_data_o  (m_data),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .done_o    (ser_done)
    );

    assign s_ready       = (state_q == ST_FILL);
    assign Plain         = plain_q;
    assign Key           = key_q;
    assign encrypt_start = start_q;
    assign timeout_err   = tmo_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_encrypt_stream_ctrl.sv
module tb_encrypt_stream_ctrl;
    import encrypt_stream_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock;
    logic reset;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- DUT signals ----------------
    logic [7:0]   s_data;
    logic         s_valid;
    logic         s_ready;
    logic [0:63]  key_in;
    logic         key_load;
    logic [7:0]   m_data;
    logic         m_valid;
    logic         m_ready;
    logic [0:127] Plain;
    logic [0:63]  Key;
    logic         encrypt_start;
    logic         encrypt_end;
    logic [0:127] Cipher;
    logic         timeout_err;
    logic [1:0]   dbg_state;

    encrypt_stream_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .key_in        (key_in),
        .key_load      (key_load),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .Plain         (Plain),
        .Key           (Key),
        .encrypt_start (encrypt_start),
        .encrypt_end   (encrypt_end),
        .Cipher        (Cipher),
        .timeout_err   (timeout_err),
        .dbg_state     (dbg_state)
    );

    // ---------------- core model ----------------
    // Golden block function of the stand-in core.
    function automatic logic [127:0] golden(input logic [127:0] p, input logic [63:0] k);
        return {p[119:0], p[127:120]} ^ {k, ~k};
    endfunction

    logic [7:0] core_cnt;
    logic       stub_hang;

    always @(posedge clock) begin
        if (reset || !encrypt_start) core_cnt <= 8'd0;
        else if (core_cnt != 8'hFF)  core_cnt <= core_cnt + 8'd1;
    end

    // End after 32 start-high edges; later cycles give different Cipher values.
    assign encrypt_end = !stub_hang && (core_cnt >= 8'd32);
    assign Cipher = (core_cnt >= 8'd32) ? golden(Plain, Key) + 128'(core_cnt - 8'd32)
                                        : ~golden(Plain, Key);

    // ---------------- scoreboard ----------------
    int n_pass;
    int n_total;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [63:0]  key;
        logic [7:0]   base;
        logic [7:0]   step;
        bit           stall;
        bit           gaps;
        logic [127:0] exp_plain;
    } vec_t;

    vec_t vecs[3];

    // ---------------- driver tasks ----------------
    task automatic load_key(input logic [63:0] k);
        key_in   = k;
        key_load = 1'b1;
        @(negedge clock);
        key_load = 1'b0;
        chk("key_loaded", 128'(Key), 128'(k));
    endtask

    // Ends at the negedge just after the edge that took the last byte.
    task automatic stream(input logic [7:0] base, input logic [7:0] step, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_valid = 1'b0;
                @(negedge clock);
            end
            chk("s_ready_fill", 128'(s_ready), 128'(1));
            s_valid = 1'b1;
            s_data  = base + 8'(i) * step;
            @(negedge clock);
        end
        s_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_plain"},   128'(Plain),         128'(0));
        chk({tag, "_key"},     128'(Key),           128'(0));
        chk({tag, "_start"},   128'(encrypt_start), 128'(0));
        chk({tag, "_mvalid"},  128'(m_valid),       128'(0));
        chk({tag, "_mdata"},   128'(m_data),        128'(0));
        chk({tag, "_timeout"}, 128'(timeout_err),   128'(0));
        chk({tag, "_sready"},  128'(s_ready),       128'(1));
        chk({tag, "_state"},   128'(dbg_state),     128'(ST_FILL));
    endtask

    task automatic run_block(input int idx);
        vec_t         v;
        logic [127:0] exp_c;
        int           n;
        int           got;
        int           cyc;
        logic [7:0]   held;
        bit           was_stall;
        v     = vecs[idx];
        exp_c = golden(v.exp_plain, v.key);
        m_ready = 1'b0;
        load_key(v.key);
        stream(v.base, v.step, 16, v.gaps);
        // LOAD cycle
        chk("load_start_low", 128'(encrypt_start), 128'(0));
        chk("load_sready",    128'(s_ready),       128'(0));
        chk("load_state",     128'(dbg_state),     128'(ST_LOAD));
        chk("plain_packed",   128'(Plain),         v.exp_plain);
        // Key writes and bytes offered outside FILL must be ignored.
        key_in   = ~v.key;
        key_load = 1'b1;
        s_valid  = 1'b1;
        s_data   = 8'hEE;
        @(negedge clock);
        n = 2;
        chk("start_rise", 128'(encrypt_start), 128'(1));
        chk("run_state",  128'(dbg_state),     128'(ST_RUN));
        while (!m_valid && n < 80) begin
            @(negedge clock);
            n++;
        end
        chk("block_latency", 128'(n), 128'(35));
        chk("start_cleared", 128'(encrypt_start), 128'(0));
        // DRAIN
        got = 0;
        cyc = 0;
        held = 8'h00;
        was_stall = 1'b0;
        while (got < 16 && cyc < 200) begin
            chk("m_valid_drain", 128'(m_valid), 128'(1));
            chk("s_ready_drain", 128'(s_ready), 128'(0));
            chk("m_data_byte",   128'(m_data),  128'(exp_c[127 - got*8 -: 8]));
            if (was_stall) chk("m_data_hold", 128'(m_data), 128'(held));
            m_ready   = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            was_stall = !m_ready;
            held      = m_data;
            if (m_ready) got++;
            @(negedge clock);
            cyc++;
        end
        s_valid  = 1'b0;
        key_load = 1'b0;
        m_ready  = 1'b1;
        chk("drain_bounded",  128'(cyc < 200),  128'(1));
        chk("drain_mvalid0",  128'(m_valid),    128'(0));
        chk("drain_sready1",  128'(s_ready),    128'(1));
        chk("drain_state",    128'(dbg_state),  128'(ST_FILL));
        chk("key_unchanged",  128'(Key),        128'(v.key));
        @(negedge clock);
        chk("no_extra_byte",  128'(m_valid),    128'(0));
        m_ready = 1'b0;
    endtask

    // ---------------- global bound ----------------
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        n_pass    = 0;
        n_total   = 0;
        stub_hang = 1'b0;
        reset     = 1'b1;
        s_data    = 8'h00;
        s_valid   = 1'b0;
        key_in    = '0;
        key_load  = 1'b0;
        m_ready   = 1'b0;

        vecs[0] = '{key: 64'h0123456789ABCDEF, base: 8'h00, step: 8'h01, stall: 1'b0, gaps: 1'b0,
                    exp_plain: 128'h000102030405060708090A0B0C0D0E0F};
        vecs[1] = '{key: 64'hFEDCBA9876543210, base: 8'hF0, step: 8'h01, stall: 1'b1, gaps: 1'b1,
                    exp_plain: 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF};
        vecs[2] = '{key: 64'h0000000000000000, base: 8'h11, step: 8'h11, stall: 1'b1, gaps: 1'b0,
                    exp_plain: 128'h112233445566778899AABBCCDDEEFF10};

        repeat (2) @(negedge clock);
        chk_reset_vals("reset");
        reset = 1'b0;
        @(negedge clock);
        chk("post_reset_sready", 128'(s_ready), 128'(1));

        for (int i = 0; i < 3; i++) run_block(i);

        // Core that never finishes: watchdog abort after 48 RUN cycles.
        stub_hang = 1'b1;
        load_key(vecs[0].key);
        stream(vecs[0].base, vecs[0].step, 16, 1'b0);
        @(negedge clock);
        chk("to_start_rise", 128'(encrypt_start), 128'(1));
        repeat (47) @(negedge clock);
        chk("to_before_err",   128'(timeout_err),   128'(0));
        chk("to_before_start", 128'(encrypt_start), 128'(1));
        @(negedge clock);
        chk("to_err_pulse",  128'(timeout_err),   128'(1));
        chk("to_start_low",  128'(encrypt_start), 128'(0));
        chk("to_sready",     128'(s_ready),       128'(1));
        chk("to_state_fill", 128'(dbg_state),     128'(ST_FILL));
        chk("to_no_mvalid",  128'(m_valid),       128'(0));
        @(negedge clock);
        chk("to_err_one_cycle", 128'(timeout_err), 128'(0));
        stub_hang = 1'b0;
        run_block(1);

        // Reset in the middle of FILL (after 7 bytes).
        load_key(vecs[1].key);
        stream(8'hA0, 8'h01, 7, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        chk_reset_vals("rst_fill");
        reset = 1'b0;
        @(negedge clock);
        run_block(2);

        // Reset in the middle of RUN.
        load_key(vecs[1].key);
        stream(vecs[1].base, vecs[1].step, 16, 1'b0);
        repeat (10) @(negedge clock);
        chk("mid_run_start", 128'(encrypt_start), 128'(1));
        reset = 1'b1;
        @(negedge clock);
        chk_reset_vals("rst_run");
        reset = 1'b0;
        @(negedge clock);
        run_block(0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
